// File: rtl/prefetch_engine_pkg.sv
`default_nettype none
// ============================================================
// prefetch_pkg : shared states, mode codes and lane helper
// Rev 1.0
// ============================================================
package prefetch_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_ISSUE_IDX  = 4'd1,
    S_WAIT_IDX   = 4'd2,
    S_ISSUE_DATA = 4'd3,
    S_WAIT_DATA  = 4'd4,
    S_WRITE      = 4'd5,
    S_DONE       = 4'd6
  } state_t;

  localparam logic MODE_STREAM   = 1'b0;
  localparam logic MODE_INDIRECT = 1'b1;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prefetch_engine_if.sv
`default_nettype none
// ============================================================
// prefetch_engine_if : cache read port and store-buffer write port
// Rev 1.0
// ============================================================
interface prefetch_engine_if #(
  parameter int LANES  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                    cache_data_req_o;
  logic [LANES-1:0]        cache_lane_en_o;
  logic [LANES*ADDR_W-1:0] cache_r_addr_o;
  logic                    wait_cache;
  logic                    cache_data_ready;
  logic [LANES*DATA_W-1:0] cache_data_i;
  logic [LANES-1:0]        strBuf_wren_o;
  logic [LANES*ADDR_W-1:0] w_addr_o;
  logic [LANES*DATA_W-1:0] w_data_o;
  logic                    wait_strBuf;

  modport master (
    output cache_data_req_o, cache_lane_en_o, cache_r_addr_o,
    output strBuf_wren_o, w_addr_o, w_data_o,
    input  wait_cache, cache_data_ready, cache_data_i, wait_strBuf
  );

  modport slave (
    input  cache_data_req_o, cache_lane_en_o, cache_r_addr_o,
    input  strBuf_wren_o, w_addr_o, w_data_o,
    output wait_cache, cache_data_ready, cache_data_i, wait_strBuf
  );
endinterface
`default_nettype wire

// File: rtl/prefetch_engine_addr_gen.sv
`default_nettype none
// ============================================================
// prefetch_addr_gen : per-lane running read/write address registers
// Rev 1.0
// ============================================================
module prefetch_addr_gen #(
  parameter int LANE   = 0,
  parameter int LANES  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] cfg_base_a,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [ADDR_W-1:0] cfg_wbase,
  input  logic              advance,
  input  logic [ADDR_W-1:0] rd_step,
  input  logic              idx_we,
  input  logic [DATA_W-1:0] idx_in,
  input  logic              use_idx,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [4:0]        shift,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr
);
  localparam int                BYTES     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] WR_OFFSET = ADDR_W'(LANE * BYTES);
  localparam logic [ADDR_W-1:0] WR_STEP   = ADDR_W'(LANES * BYTES);

  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] rd_offset;

  // LANE*stride as a short adder chain rather than a multiplier
  always_comb begin
    rd_offset = '0;
    for (int j = 0; j < LANE; j++) rd_offset = rd_offset + cfg_stride;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_addr <= '0;
      w_addr <= '0;
      idx    <= '0;
    end else begin
      if (load) begin
        a_addr <= cfg_base_a + rd_offset;
        w_addr <= cfg_wbase + WR_OFFSET;
      end else if (advance) begin
        a_addr <= a_addr + rd_step;
        w_addr <= w_addr + WR_STEP;
      end
      if (idx_we) idx <= ADDR_W'(idx_in);
    end
  end

  assign rd_addr = use_idx ? (base_b + (idx << shift)) : a_addr;
  assign wr_addr = w_addr;

endmodule
`default_nettype wire

// File: rtl/prefetch_engine.sv
`default_nettype none
// ============================================================
// prefetch_engine : stream / one-level indirect multi-lane prefetcher
// Rev 1.0
// ============================================================
module prefetch_engine
  import prefetch_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic              mode,
  input  logic [ADDR_W-1:0] cfg_base_a,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [ADDR_W-1:0] cfg_base_b,
  input  logic [4:0]        cfg_shift,
  input  logic [ADDR_W-1:0] cfg_wbase,
  input  logic [CNT_W-1:0]  cfg_count,
  prefetch_engine_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic [3:0]        outState
);
  state_t state, state_nx;

  logic                    mode_q;
  logic [ADDR_W-1:0]       base_b_q;
  logic [ADDR_W-1:0]       rd_step;
  logic [ADDR_W-1:0]       step_sum;
  logic [4:0]              shift_q;
  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        elem;
  logic [LANES*DATA_W-1:0] data_q;
  logic [CNT_W:0]          remaining;
  logic [CNT_W:0]          batch_n;
  logic [CNT_W:0]          elem_nx;
  logic [LANES-1:0]        lane_act;
  logic [LANES*ADDR_W-1:0] rd_addr;
  logic [LANES*ADDR_W-1:0] wr_addr;
  logic start, issuing, writing, wr_accept, use_idx, idx_we;

  assign start     = (state == S_IDLE) && trigger;
  assign issuing   = (state == S_ISSUE_IDX) || (state == S_ISSUE_DATA);
  assign writing   = (state == S_WRITE);
  assign wr_accept = writing && !bus.wait_strBuf;
  assign use_idx   = (state == S_ISSUE_DATA) && (mode_q == MODE_INDIRECT);
  assign idx_we    = (state == S_WAIT_IDX) && bus.cache_data_ready;

  assign remaining = {1'b0, count_q} - {1'b0, elem};
  assign batch_n   = (remaining > (CNT_W+1)'(LANES)) ? (CNT_W+1)'(LANES) : remaining;
  assign elem_nx   = {1'b0, elem} + batch_n;

  always_comb begin
    step_sum = '0;
    for (int j = 0; j < LANES; j++) step_sum = step_sum + cfg_stride;
    lane_act = '0;
    for (int k = 0; k < LANES; k++) lane_act[k] = (remaining > (CNT_W+1)'(k));
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (trigger) begin
        if (cfg_count == '0)            state_nx = S_DONE;
        else if (mode == MODE_INDIRECT) state_nx = S_ISSUE_IDX;
        else                            state_nx = S_ISSUE_DATA;
      end
      S_ISSUE_IDX:  if (!bus.wait_cache)      state_nx = S_WAIT_IDX;
      S_WAIT_IDX:   if (bus.cache_data_ready) state_nx = S_ISSUE_DATA;
      S_ISSUE_DATA: if (!bus.wait_cache)      state_nx = S_WAIT_DATA;
      S_WAIT_DATA:  if (bus.cache_data_ready) state_nx = S_WRITE;
      S_WRITE: if (!bus.wait_strBuf) begin
        if (elem_nx >= {1'b0, count_q})  state_nx = S_DONE;
        else if (mode_q == MODE_INDIRECT) state_nx = S_ISSUE_IDX;
        else                              state_nx = S_ISSUE_DATA;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      mode_q   <= MODE_STREAM;
      base_b_q <= '0;
      rd_step  <= '0;
      shift_q  <= '0;
      count_q  <= '0;
      elem     <= '0;
      data_q   <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        mode_q   <= mode;
        base_b_q <= cfg_base_b;
        rd_step  <= step_sum;
        shift_q  <= cfg_shift;
        count_q  <= cfg_count;
        elem     <= '0;
      end else if (wr_accept) begin
        elem <= elem_nx[CNT_W-1:0];
      end
      if ((state == S_WAIT_DATA) && bus.cache_data_ready) data_q <= bus.cache_data_i;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    prefetch_addr_gen #(
      .LANE(g), .LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .load       (start),
      .cfg_base_a (cfg_base_a),
      .cfg_stride (cfg_stride),
      .cfg_wbase  (cfg_wbase),
      .advance    (wr_accept),
      .rd_step    (rd_step),
      .idx_we     (idx_we),
      .idx_in     (bus.cache_data_i[g*DATA_W +: DATA_W]),
      .use_idx    (use_idx),
      .base_b     (base_b_q),
      .shift      (shift_q),
      .rd_addr    (rd_addr[g*ADDR_W +: ADDR_W]),
      .wr_addr    (wr_addr[g*ADDR_W +: ADDR_W])
    );
  end

  // Idle lanes drive zeros so the consumers never see stale addresses
  always_comb begin
    bus.cache_data_req_o = issuing;
    bus.cache_lane_en_o  = '0;
    bus.cache_r_addr_o   = '0;
    bus.strBuf_wren_o    = '0;
    bus.w_addr_o         = '0;
    bus.w_data_o         = '0;
    for (int k = 0; k < LANES; k++) begin
      if (issuing && lane_act[k]) begin
        bus.cache_lane_en_o[k] = 1'b1;
        bus.cache_r_addr_o[lane_lo(k, ADDR_W) +: ADDR_W] = rd_addr[lane_lo(k, ADDR_W) +: ADDR_W];
      end
      if (writing && lane_act[k]) begin
        bus.strBuf_wren_o[k] = 1'b1;
        bus.w_addr_o[lane_lo(k, ADDR_W) +: ADDR_W] = wr_addr[lane_lo(k, ADDR_W) +: ADDR_W];
        bus.w_data_o[lane_lo(k, DATA_W) +: DATA_W] = data_q[lane_lo(k, DATA_W) +: DATA_W];
      end
    end
  end

  assign busy_o   = (state != S_IDLE) && (state != S_DONE);
  assign done_o   = (state == S_DONE);
  assign outState = state;

endmodule
`default_nettype wire

// File: tb/tb_prefetch_engine.sv
`default_nettype none
// ============================================================
// tb_prefetch_engine : directed checks with a behavioural cache and store buffer
// Rev 1.0
// ============================================================
module tb_prefetch_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] cfg_base_a = '0, cfg_stride = '0, cfg_base_b = '0, cfg_wbase = '0;
  logic [4:0]  cfg_shift = '0;
  logic [15:0] cfg_count = '0;
  logic        busy_o, done_o;
  logic [3:0]  outState;

  prefetch_engine_if #(.LANES(2), .ADDR_W(32), .DATA_W(32)) bus ();

  prefetch_engine #(.LANES(2), .ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .mode(mode),
    .cfg_base_a(cfg_base_a), .cfg_stride(cfg_stride), .cfg_base_b(cfg_base_b),
    .cfg_shift(cfg_shift), .cfg_wbase(cfg_wbase), .cfg_count(cfg_count),
    .bus(bus), .busy_o(busy_o), .done_o(done_o), .outState(outState)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cache answers index reads at 0x100/0x104 with 5/7 and echoes every other address
  function automatic logic [31:0] resp(input logic [31:0] a);
    if (a == 32'h100) return 32'd5;
    if (a == 32'h104) return 32'd7;
    return a;
  endfunction

  logic        pend = 1'b0;
  logic [63:0] paddr = '0;
  logic [31:0] rd_log[$], wa[$], wd[$];
  int          n_racc = 0, n_wacc = 0, n_done = 0;
  logic        busy_seen = 1'b0;
  logic [1:0]  last_en = '0, last_wren = '0;
  logic [31:0] last_l1 = '0, last_wa1 = '0;

  always @(posedge clk) begin
    if (bus.cache_data_req_o && !bus.wait_cache) begin
      pend  = 1'b1;
      paddr = bus.cache_r_addr_o;
      n_racc++;
      last_en = bus.cache_lane_en_o;
      last_l1 = bus.cache_r_addr_o[63:32];
      for (int k = 0; k < 2; k++)
        if (bus.cache_lane_en_o[k]) rd_log.push_back(bus.cache_r_addr_o[k*32 +: 32]);
    end
    if (bus.strBuf_wren_o != 2'b00 && !bus.wait_strBuf) begin
      n_wacc++;
      last_wren = bus.strBuf_wren_o;
      last_wa1  = bus.w_addr_o[63:32];
      for (int k = 0; k < 2; k++)
        if (bus.strBuf_wren_o[k]) begin
          wa.push_back(bus.w_addr_o[k*32 +: 32]);
          wd.push_back(bus.w_data_o[k*32 +: 32]);
        end
    end
    if (done_o) n_done++;
    if (busy_o) busy_seen = 1'b1;
  end

  always @(negedge clk) begin
    bus.cache_data_ready = 1'b0;
    if (pend) begin
      bus.cache_data_ready = 1'b1;
      bus.cache_data_i     = {resp(paddr[63:32]), resp(paddr[31:0])};
      pend = 1'b0;
    end
  end

  task automatic clear_logs();
    rd_log.delete(); wa.delete(); wd.delete();
    n_racc = 0; n_wacc = 0; n_done = 0; busy_seen = 1'b0;
  endtask

  // Returns at the first negedge after the trigger cycle (trigger cycle t -> t+1)
  task automatic start(input logic m, input logic [31:0] ba, input logic [31:0] st,
                       input logic [31:0] bb, input logic [4:0] sh,
                       input logic [31:0] wb, input logic [15:0] cnt);
    @(negedge clk);
    mode = m; cfg_base_a = ba; cfg_stride = st; cfg_base_b = bb;
    cfg_shift = sh; cfg_wbase = wb; cfg_count = cnt; trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done"}, {63'd0, done_o}, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    bus.wait_cache = 1'b0; bus.wait_strBuf = 1'b0;
    bus.cache_data_ready = 1'b0; bus.cache_data_i = '0;
    repeat (3) @(negedge clk);
    check("rst req",   {63'd0, bus.cache_data_req_o}, 64'd0);
    check("rst state", {60'd0, outState}, 64'd0);
    check("rst busy",  {62'd0, busy_o, done_o}, 64'd0);
    reset = 1'b0;

    // stream, two full batches
    clear_logs();
    start(1'b0, 32'h1000, 32'd8, 32'h0, 5'd0, 32'h2000, 16'd4);
    check("s4 req t+1", {63'd0, bus.cache_data_req_o}, 64'd1);
    check("s4 addr t+1", bus.cache_r_addr_o, 64'h00001008_00001000);
    wait_done("s4");
    check("s4 nreads", rd_log.size(), 64'd4);
    check("s4 nwrites", wa.size(), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s4 rd%0d", i), {32'd0, rd_log[i]}, 64'h1000 + 64'(8 * i));
      check($sformatf("s4 wa%0d", i), {32'd0, wa[i]}, 64'h2000 + 64'(4 * i));
      check($sformatf("s4 wd%0d", i), {32'd0, wd[i]}, 64'h1000 + 64'(8 * i));
    end
    check("s4 ndone", n_done, 64'd1);

    // stream, partial last batch
    clear_logs();
    start(1'b0, 32'h1000, 32'd8, 32'h0, 5'd0, 32'h2000, 16'd3);
    wait_done("s3");
    check("s3 nreads", rd_log.size(), 64'd3);
    check("s3 nwrites", wa.size(), 64'd3);
    check("s3 last wa", {32'd0, wa[2]}, 64'h2008);
    check("s3 last wd", {32'd0, wd[2]}, 64'h1010);
    check("s3 lane_en", {62'd0, last_en}, 64'd1);
    check("s3 lane1 raddr", {32'd0, last_l1}, 64'd0);
    check("s3 wren", {62'd0, last_wren}, 64'd1);
    check("s3 lane1 waddr", {32'd0, last_wa1}, 64'd0);

    // indirect
    clear_logs();
    start(1'b1, 32'h100, 32'd4, 32'h4000, 5'd2, 32'h3000, 16'd2);
    check("ind idx addr", bus.cache_r_addr_o, 64'h00000104_00000100);
    wait_done("ind");
    check("ind nreads", rd_log.size(), 64'd4);
    check("ind rd2", {32'd0, rd_log[2]}, 64'h4014);
    check("ind rd3", {32'd0, rd_log[3]}, 64'h401C);
    check("ind wa0", {32'd0, wa[0]}, 64'h3000);
    check("ind wa1", {32'd0, wa[1]}, 64'h3004);
    check("ind wd0", {32'd0, wd[0]}, 64'h4014);
    check("ind wd1", {32'd0, wd[1]}, 64'h401C);

    // stalls on both ports
    clear_logs();
    bus.wait_cache = 1'b1; bus.wait_strBuf = 1'b1;
    start(1'b0, 32'h1000, 32'd8, 32'h0, 5'd0, 32'h2000, 16'd4);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall req%0d", i), {63'd0, bus.cache_data_req_o}, 64'd1);
      check($sformatf("stall raddr%0d", i), bus.cache_r_addr_o, 64'h00001008_00001000);
      @(negedge clk);
    end
    bus.wait_cache = 1'b0;
    for (int n = 0; n < 50 && bus.strBuf_wren_o == 2'b00; n++) @(negedge clk);
    check("stall one raccept", n_racc, 64'd1);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("stall wren%0d", i), {62'd0, bus.strBuf_wren_o}, 64'd3);
      check($sformatf("stall waddr%0d", i), bus.w_addr_o, 64'h00002004_00002000);
      check($sformatf("stall wdata%0d", i), bus.w_data_o, 64'h00001008_00001000);
      @(negedge clk);
    end
    check("stall no waccept", n_wacc, 64'd0);
    bus.wait_strBuf = 1'b0;
    wait_done("stall");
    check("stall nracc", n_racc, 64'd2);
    check("stall nwacc", n_wacc, 64'd2);
    check("stall wa3", {32'd0, wa[3]}, 64'h200C);

    // zero count
    clear_logs();
    start(1'b0, 32'h1000, 32'd8, 32'h0, 5'd0, 32'h2000, 16'd0);
    check("c0 done t+1", {63'd0, done_o}, 64'd1);
    check("c0 state t+1", {60'd0, outState}, 64'd6);
    check("c0 req", {63'd0, bus.cache_data_req_o}, 64'd0);
    @(negedge clk);
    check("c0 done drop", {63'd0, done_o}, 64'd0);
    check("c0 idle", {60'd0, outState}, 64'd0);
    check("c0 busy never", {63'd0, busy_seen}, 64'd0);
    check("c0 no reads", n_racc, 64'd0);

    // reset in WAIT_DATA
    clear_logs();
    start(1'b0, 32'h1000, 32'd8, 32'h0, 5'd0, 32'h2000, 16'd4);
    for (int n = 0; n < 20 && outState != 4'd4; n++) @(negedge clk);
    check("rstmid reached wait", {60'd0, outState}, 64'd4);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid state", {60'd0, outState}, 64'd0);
    check("rstmid ctl", {59'd0, bus.cache_data_req_o, bus.strBuf_wren_o, busy_o, done_o}, 64'd0);
    check("rstmid raddr", bus.cache_r_addr_o, 64'd0);
    check("rstmid waddr", bus.w_addr_o, 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rstmid no writes", wa.size(), 64'd0);
    check("rstmid no done", n_done, 64'd0);

    // second trigger while busy is ignored
    clear_logs();
    start(1'b0, 32'h1000, 32'd8, 32'h0, 5'd0, 32'h2000, 16'd4);
    mode = 1'b1; cfg_base_a = 32'h9000; cfg_wbase = 32'h5000; cfg_count = 16'd0;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    wait_done("retrig");
    check("retrig nwrites", wa.size(), 64'd4);
    check("retrig rd2", {32'd0, rd_log[2]}, 64'h1010);
    check("retrig wa3", {32'd0, wa[3]}, 64'h200C);
    check("retrig wd3", {32'd0, wd[3]}, 64'h1018);
    check("retrig ndone", n_done, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prefetch_engine.md
Name: prefetch_engine

Overview:
Parametrised, runtime-configurable successor to the fixed-kernel prefetcher. Replaces per-kernel hardwired sequences with two selectable modes: strided stream (A[i]) and one-level indirect (B[A[i]]). Issues LANES parallel reads to the cache port and writes the results into the store buffer. Sits between the trigger/config source and the cache and store buffer, using the same req/wait/ready handshake as the existing prefetcher.

Parameters:
LANES, 2, parallel read/write lanes (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width; write-address increment is DATA_W/8 bytes
CNT_W, 16, element-count width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
trigger  in  1  one-cycle start pulse; config sampled on this cycle
mode  in  1  0 = stream, 1 = indirect
cfg_base_a  in  ADDR_W  stream / index-array base (bytes)
cfg_stride  in  ADDR_W  byte stride between A elements
cfg_base_b  in  ADDR_W  indirect target base
cfg_shift  in  5  indirect index left shift
cfg_wbase  in  ADDR_W  store-buffer write base
cfg_count  in  CNT_W  number of elements
cache_data_req_o  out  1  read request
cache_lane_en_o  out  LANES  active-lane mask for the request
cache_r_addr_o  out  LANES*ADDR_W  per-lane read address, lane 0 in LSBs
wait_cache  in  1  cache stall; request accepted on a cycle with req=1 and wait=0
cache_data_ready  in  1  one-cycle read-data valid
cache_data_i  in  LANES*DATA_W  per-lane read data
strBuf_wren_o  out  LANES  per-lane write enable
w_addr_o  out  LANES*ADDR_W  write addresses
w_data_o  out  LANES*DATA_W  write data
wait_strBuf  in  1  store-buffer stall; write accepted when wren≠0 and wait=0
busy_o  out  1  high from the cycle after an accepted trigger until DONE
done_o  out  1  one-cycle completion pulse
outState  out  4  current state encoding

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters and registers cleared. Reset mid-operation aborts immediately; no further requests or writes are issued.
- State encoding: IDLE=0, ISSUE_IDX=1, WAIT_IDX=2, ISSUE_DATA=3, WAIT_DATA=4, WRITE=5, DONE=6.
- IDLE + trigger: latch cfg_* and mode; set i=0.
  - cfg_count=0: go to DONE.
  - mode=1: go to ISSUE_IDX.
  - mode=0: go to ISSUE_DATA.
  - trigger outside IDLE is ignored.
- Batch: n = min(LANES, count−i). Lane k (k<n) is active.
  - Inactive lanes: address 0, wren 0, lane_en 0.
- ISSUE_IDX:
  - req=1, addr_k = base_a + (i+k)*stride, mod 2^ADDR_W.
  - Hold req, addresses and mask stable until accept, then req=0 and go to WAIT_IDX.
- WAIT_IDX:
  - On cache_data_ready, capture idx_k, zero-extended or truncated to ADDR_W.
  - Go to ISSUE_DATA.
- ISSUE_DATA:
  - Addresses: stream addr_k = base_a + (i+k)*stride; indirect addr_k = base_b + (idx_k << shift), mod 2^ADDR_W.
  - Same hold/accept rule as ISSUE_IDX; then go to WAIT_DATA.
- WAIT_DATA: on ready, capture data_k and go to WRITE.
- WRITE:
  - wren_k=1 for active lanes, w_addr_k = wbase + (i+k)*(DATA_W/8), w_data_k = data_k.
  - Hold until accept. Then i += n.
  - If i ≥ count: go to DONE. Otherwise go to ISSUE_IDX (indirect) or ISSUE_DATA (stream).
- DONE: done_o=1 and busy_o=0 for one cycle, then IDLE.
- busy_o=1 in states 1–5.
- Timing: a trigger at cycle t puts the first request on the outputs at t+1.
- cache_data_ready outside WAIT_* states is ignored.
- Per-lane multiplies are implemented as running per-lane address registers advanced by LANES*stride; no multipliers.

Decomposition:
- prefetch_pkg holds:
  - state enum and encodings
  - MODE_STREAM / MODE_INDIRECT constants
  - the lane-slice helper function
- One sub-module, prefetch_addr_gen (per lane):
  - Holds a running address register.
  - Load on start, advance on batch accept.
  - Selects stream or indirect address.

Test Plan:
- Stream, LANES=2, base_a=0x1000, stride=8, count=4, wbase=0x2000, cache echoes addr → reads 0x1000/0x1008 then 0x1010/0x1018; writes 0x2000..0x200C carry the echoed data; done_o pulses once.
- Stream, count=3 → second batch lane_en=01, wren=01, only write 0x2008 issued; lane 1 address 0.
- Indirect, base_a=0x100, idx data 5 and 7, base_b=0x4000, shift=2 → data reads 0x4014/0x401C; writes go to wbase and wbase+4.
- wait_cache held for 3 cycles during ISSUE_DATA, then wait_strBuf held for 2 cycles → req, addresses and wren stay stable throughout; exactly one accept each; element counter advances once.
- count=0 trigger at t → no req; done_o=1 at t+1; busy_o never 1.
- Reset asserted in WAIT_DATA, then a trigger while busy in a fresh run → all outputs 0 the next cycle and outState=0; the second trigger has no effect on the running sequence.
